// File: rtl/accel_csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accel_csr_pkg
//  Description : Shared definitions for the accelerator CSR block: register
//                byte addresses, CTRL/STATUS bit positions and the packed
//                layer-configuration record.
//  Revision    : 1.0 - initial release
// ============================================================================
package accel_csr_pkg;

    // Register byte addresses (bits [1:0] are ignored by the decoder)
    localparam logic [7:0] CSR_CTRL      = 8'h00;
    localparam logic [7:0] CSR_STATUS    = 8'h04;
    localparam logic [7:0] CSR_DIM_M     = 8'h08;
    localparam logic [7:0] CSR_DIM_N     = 8'h0C;
    localparam logic [7:0] CSR_DIM_K     = 8'h10;
    localparam logic [7:0] CSR_SRC_ADDR  = 8'h14;
    localparam logic [7:0] CSR_DST_ADDR  = 8'h18;
    localparam logic [7:0] CSR_CYCLE_CNT = 8'h1C;
    localparam logic [7:0] CSR_DONE_CNT  = 8'h20;
    localparam logic [7:0] CSR_VERSION   = 8'h24;

    // CTRL bit positions
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_ABORT_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    // STATUS bit positions
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    // Storage widths of the configuration record; the top level exposes
    // DIM_WIDTH / DATA_WIDTH slices of these fields, so those parameters
    // must not exceed these widths.
    localparam int CFG_DIM_W  = 16;
    localparam int CFG_ADDR_W = 32;

    typedef struct packed {
        logic [CFG_DIM_W-1:0]  m;
        logic [CFG_DIM_W-1:0]  n;
        logic [CFG_DIM_W-1:0]  k;
        logic [CFG_ADDR_W-1:0] src;
        logic [CFG_ADDR_W-1:0] dst;
    } cfg_t;

endpackage : accel_csr_pkg
`default_nettype wire

// File: rtl/csr_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : csr_sat_counter
//  Description : Up-counter with synchronous clear. Either saturates at
//                all-ones or wraps to zero, selected by SATURATE.
//  Ports       : clk, rst_n  - clock, async active-low reset
//                clr_i       - clear to zero (has priority over inc_i)
//                inc_i       - increment by one
//                cnt_o       - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_sat_counter #(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             w_hold;

    generate
        if (SATURATE) begin : g_saturate
            assign w_hold = &cnt_q;
        end else begin : g_wrap
            assign w_hold = 1'b0;
        end
    endgenerate

    assign cnt_d = clr_i              ? '0 :
                   (inc_i && !w_hold) ? cnt_q + WIDTH'(1) :
                                        cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : csr_sat_counter
`default_nettype wire

// File: rtl/accel_csr_regs.sv
`default_nettype none
// ============================================================================
//  Module      : accel_csr_regs
//  Description : CSR register file for the accelerator engine. Decodes the
//                write/read strobes from the AXI4-Lite slave, holds the layer
//                configuration, runs the START/ABORT/DONE job handshake,
//                keeps sticky DONE/ERR flags, a level IRQ and two perf
//                counters (busy cycles, completed jobs).
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                csr_wen/ren/addr/wdata     - register access strobes
//                csr_rdata                  - combinational read data
//                eng_start/eng_abort        - one-cycle pulses to the engine
//                eng_done/eng_err           - one-cycle pulses from the engine
//                cfg_m/n/k/src/dst          - layer configuration
//                irq                        - registered level interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module accel_csr_regs
    import accel_csr_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DIM_WIDTH  = 16,
    parameter int                    CNT_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] VERSION    = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csr_wen,
    input  logic                  csr_ren,
    input  logic [ADDR_WIDTH-1:0] csr_addr,
    input  logic [DATA_WIDTH-1:0] csr_wdata,
    output logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  eng_start,
    output logic                  eng_abort,
    input  logic                  eng_done,
    input  logic                  eng_err,
    output logic [DIM_WIDTH-1:0]  cfg_m,
    output logic [DIM_WIDTH-1:0]  cfg_n,
    output logic [DIM_WIDTH-1:0]  cfg_k,
    output logic [DATA_WIDTH-1:0] cfg_src,
    output logic [DATA_WIDTH-1:0] cfg_dst,
    output logic                  irq
);

    localparam logic [ADDR_WIDTH-1:0] c_addr_ctrl   = ADDR_WIDTH'(CSR_CTRL);
    localparam logic [ADDR_WIDTH-1:0] c_addr_status = ADDR_WIDTH'(CSR_STATUS);
    localparam logic [ADDR_WIDTH-1:0] c_addr_dim_m  = ADDR_WIDTH'(CSR_DIM_M);
    localparam logic [ADDR_WIDTH-1:0] c_addr_dim_n  = ADDR_WIDTH'(CSR_DIM_N);
    localparam logic [ADDR_WIDTH-1:0] c_addr_dim_k  = ADDR_WIDTH'(CSR_DIM_K);
    localparam logic [ADDR_WIDTH-1:0] c_addr_src    = ADDR_WIDTH'(CSR_SRC_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_addr_dst    = ADDR_WIDTH'(CSR_DST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_addr_cycle  = ADDR_WIDTH'(CSR_CYCLE_CNT);
    localparam logic [ADDR_WIDTH-1:0] c_addr_donec  = ADDR_WIDTH'(CSR_DONE_CNT);
    localparam logic [ADDR_WIDTH-1:0] c_addr_ver    = ADDR_WIDTH'(CSR_VERSION);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic irq_en_q, irq_en_d;
    logic busy_q,   busy_d;
    logic done_q,   done_d;
    logic err_q,    err_d;
    logic start_q,  start_d;
    logic abort_q,  abort_d;
    logic irq_q,    irq_d;
    cfg_t cfg_q,    cfg_d;

    logic [CNT_WIDTH-1:0] w_cycle_cnt;
    logic [CNT_WIDTH-1:0] w_done_cnt;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_word;
    logic w_wr_ctrl, w_wr_status, w_wr_cfg;
    logic w_dims_ok, w_start_req, w_start_ok, w_start_rej;
    logic w_abort_ok, w_done_evt, w_cfg_blocked;
    logic w_unused;

    assign w_word      = {csr_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_wr_ctrl   = csr_wen && (w_word == c_addr_ctrl);
    assign w_wr_status = csr_wen && (w_word == c_addr_status);
    assign w_wr_cfg    = csr_wen && ((w_word == c_addr_dim_m) || (w_word == c_addr_dim_n) ||
                                     (w_word == c_addr_dim_k) || (w_word == c_addr_src)   ||
                                     (w_word == c_addr_dst));

    // Reads have no side effects, so the read strobe carries no information
    assign w_unused = ^{csr_ren, csr_addr[1:0]};

    // ------------------------------------------------------------------
    // Job handshake
    // ------------------------------------------------------------------
    assign w_dims_ok   = (cfg_m != '0) && (cfg_n != '0) && (cfg_k != '0);
    assign w_start_req = w_wr_ctrl && csr_wdata[CTRL_START_BIT];
    // A done pulse arriving with START blocks the accept so the pulse is
    // never mistaken for completion of the new job.
    assign w_start_ok  = w_start_req && !busy_q && w_dims_ok && !eng_done;
    assign w_start_rej = w_start_req && !w_start_ok;
    // Done wins over a simultaneous abort
    assign w_abort_ok  = w_wr_ctrl && csr_wdata[CTRL_ABORT_BIT] && busy_q && !eng_done;
    assign w_done_evt  = eng_done && busy_q;
    assign w_cfg_blocked = w_wr_cfg && busy_q;

    assign busy_d   = w_start_ok || (busy_q && !w_done_evt && !w_abort_ok);
    assign start_d  = w_start_ok;
    assign abort_d  = w_abort_ok;
    assign irq_en_d = w_wr_ctrl ? csr_wdata[CTRL_IRQ_EN_BIT] : irq_en_q;

    // Sticky flags: set event has priority over a same-cycle W1C
    assign done_d = w_done_evt ||
                    (done_q && !(w_wr_status && csr_wdata[STAT_DONE_BIT]));
    assign err_d  = eng_err || w_start_rej || w_cfg_blocked ||
                    (err_q && !(w_wr_status && csr_wdata[STAT_ERR_BIT]));

    assign irq_d  = irq_en_q && (done_q || err_q);

    // Configuration is frozen while a job runs
    always_comb begin
        cfg_d = cfg_q;
        if (csr_wen && !busy_q) begin
            case (w_word)
                c_addr_dim_m: cfg_d.m   = CFG_DIM_W'(csr_wdata[DIM_WIDTH-1:0]);
                c_addr_dim_n: cfg_d.n   = CFG_DIM_W'(csr_wdata[DIM_WIDTH-1:0]);
                c_addr_dim_k: cfg_d.k   = CFG_DIM_W'(csr_wdata[DIM_WIDTH-1:0]);
                c_addr_src:   cfg_d.src = CFG_ADDR_W'(csr_wdata);
                c_addr_dst:   cfg_d.dst = CFG_ADDR_W'(csr_wdata);
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            irq_q    <= 1'b0;
            cfg_q    <= '0;
        end else begin
            irq_en_q <= irq_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            abort_q  <= abort_d;
            irq_q    <= irq_d;
            cfg_q    <= cfg_d;
        end
    end

    // ------------------------------------------------------------------
    // Perf counters
    // ------------------------------------------------------------------
    csr_sat_counter #(
        .WIDTH    (CNT_WIDTH),
        .SATURATE (1'b1)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (w_start_ok),
        .inc_i (busy_q),
        .cnt_o (w_cycle_cnt)
    );

    csr_sat_counter #(
        .WIDTH    (CNT_WIDTH),
        .SATURATE (1'b0)
    ) u_done_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .inc_i (w_done_evt),
        .cnt_o (w_done_cnt)
    );

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        csr_rdata = '0;
        case (w_word)
            c_addr_ctrl:   csr_rdata = DATA_WIDTH'({irq_en_q, 2'b00});
            c_addr_status: csr_rdata = DATA_WIDTH'({err_q, done_q, busy_q});
            c_addr_dim_m:  csr_rdata = DATA_WIDTH'(cfg_m);
            c_addr_dim_n:  csr_rdata = DATA_WIDTH'(cfg_n);
            c_addr_dim_k:  csr_rdata = DATA_WIDTH'(cfg_k);
            c_addr_src:    csr_rdata = cfg_src;
            c_addr_dst:    csr_rdata = cfg_dst;
            c_addr_cycle:  csr_rdata = DATA_WIDTH'(w_cycle_cnt);
            c_addr_donec:  csr_rdata = DATA_WIDTH'(w_done_cnt);
            c_addr_ver:    csr_rdata = VERSION;
            default:       csr_rdata = '0;
        endcase
    end

    assign eng_start = start_q;
    assign eng_abort = abort_q;
    assign irq       = irq_q;
    assign cfg_m     = cfg_q.m[DIM_WIDTH-1:0];
    assign cfg_n     = cfg_q.n[DIM_WIDTH-1:0];
    assign cfg_k     = cfg_q.k[DIM_WIDTH-1:0];
    assign cfg_src   = cfg_q.src[DATA_WIDTH-1:0];
    assign cfg_dst   = cfg_q.dst[DATA_WIDTH-1:0];

endmodule : accel_csr_regs
`default_nettype wire
